// File: rtl/tower_unit_if.sv
// -----------------------------------------------------------------------------
// tower_unit_if
// Groups the gameplay-side signals of one tower: the per-cycle inputs from the
// level controller and the registered tower status going back to it.
//
//   game_tick       controller -> tower  one-clk gameplay tick enable
//   start_level     controller -> tower  level start request (honoured in IDLE)
//   player          controller -> tower  1 = player tower (right), 0 = enemy (left)
//   attack_en       controller -> tower  per-channel attack valid
//   damage_in       controller -> tower  packed damage, channel i at [i*DMG_W +: DMG_W]
//   health          tower -> controller  current hit points
//   position        tower -> controller  deploy x-position
//   alive           tower -> controller  high while the tower is in play
//   dead            tower -> controller  high during the death-hold window
//   level_complete  tower -> controller  sticky "this tower fell" flag
//   hit             tower -> controller  one-clk pulse when damage landed
//
// Modports: master = level controller side, slave = tower side.
// -----------------------------------------------------------------------------
interface tower_unit_if #(
    parameter int HP_W  = 8,
    parameter int N_ATK = 2,
    parameter int DMG_W = 8,
    parameter int POS_W = 9
);
    logic                    game_tick;
    logic                    start_level;
    logic                    player;
    logic [N_ATK-1:0]        attack_en;
    logic [N_ATK*DMG_W-1:0]  damage_in;
    logic [HP_W-1:0]         health;
    logic [POS_W-1:0]        position;
    logic                    alive;
    logic                    dead;
    logic                    level_complete;
    logic                    hit;

    modport master (
        output game_tick, start_level, player, attack_en, damage_in,
        input  health, position, alive, dead, level_complete, hit
    );

    modport slave (
        input  game_tick, start_level, player, attack_en, damage_in,
        output health, position, alive, dead, level_complete, hit
    );
endinterface

// File: rtl/tower_unit.sv
// -----------------------------------------------------------------------------
// tower_unit
// One tower of a level: hit points, deploy position and life state.
// Life cycle: IDLE -> DEPLOY (1 clk) -> ALIVE -> DEAD (DEAD_TICKS game ticks)
// -> IDLE. While ALIVE, the summed damage of all enabled channels is applied
// every clk; optional regeneration adds +1 health every REGEN_TICKS game ticks.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    tower_unit_if.slave (inputs from and status to the level controller)
// -----------------------------------------------------------------------------
module tower_unit #(
    parameter int HP_W        = 8,
    parameter int MAX_HP      = 255,
    parameter int N_ATK       = 2,
    parameter int DMG_W       = 8,
    parameter int POS_W       = 9,
    parameter int DEAD_TICKS  = 10,
    parameter int REGEN_TICKS = 0
) (
    input  logic         clk,
    input  logic         reset,
    tower_unit_if.slave  bus
);
    // Sum width is wide enough that N_ATK maximal hits can never wrap.
    localparam int SUM_W      = DMG_W + $clog2(N_ATK) + 1;
    localparam int CMP_W      = (SUM_W > HP_W) ? SUM_W : HP_W;
    localparam int DEAD_LAST  = (DEAD_TICKS > 1) ? DEAD_TICKS - 1 : 0;
    localparam int REGEN_LAST = (REGEN_TICKS > 1) ? REGEN_TICKS - 1 : 0;
    localparam int DCNT_W     = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam int RCNT_W     = (REGEN_TICKS > 1) ? $clog2(REGEN_TICKS) : 1;
    localparam bit REGEN_ON   = (REGEN_TICKS > 0);
    localparam logic [HP_W-1:0] MAX_HP_V = HP_W'(MAX_HP);

    // Three-bit encoding leaves spare codes; any of them falls back to IDLE.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DEPLOY = 3'd1,
        S_ALIVE  = 3'd2,
        S_DEAD   = 3'd3
    } state_t;

    state_t             state_reg;
    logic [HP_W-1:0]    health_reg;
    logic [POS_W-1:0]   position_reg;
    logic               alive_reg;
    logic               dead_reg;
    logic               level_complete_reg;
    logic               hit_reg;
    logic [DCNT_W-1:0]  dead_cnt_reg;
    logic [RCNT_W-1:0]  regen_cnt_reg;

    // ---------------------------------------------------------------- damage
    logic [SUM_W-1:0] masked [N_ATK];

    generate
        for (genvar gi = 0; gi < N_ATK; gi++) begin : g_mask
            assign masked[gi] = bus.attack_en[gi]
                              ? SUM_W'(bus.damage_in[gi*DMG_W +: DMG_W])
                              : '0;
        end
    endgenerate

    logic [SUM_W-1:0] dmg_sum;
    always_comb begin
        dmg_sum = '0;
        for (int i = 0; i < N_ATK; i++) begin
            dmg_sum = dmg_sum + masked[i];
        end
    end

    logic            dmg_any;
    logic            lethal;
    logic [HP_W-1:0] hp_after;
    logic            regen_due;
    logic            dead_done;

    assign dmg_any   = (dmg_sum != '0);
    assign lethal    = (CMP_W'(dmg_sum) >= CMP_W'(health_reg));
    // Only used when the hit is not lethal, so the sum fits below health.
    assign hp_after  = health_reg - HP_W'(dmg_sum);
    assign regen_due = REGEN_ON && bus.game_tick
                     && (regen_cnt_reg == RCNT_W'(REGEN_LAST));
    assign dead_done = bus.game_tick && (dead_cnt_reg == DCNT_W'(DEAD_LAST));

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg          <= S_IDLE;
            health_reg         <= MAX_HP_V;
            position_reg       <= '0;
            alive_reg          <= 1'b0;
            dead_reg           <= 1'b0;
            level_complete_reg <= 1'b0;
            hit_reg            <= 1'b0;
            dead_cnt_reg       <= '0;
            regen_cnt_reg      <= '0;
        end else begin
            hit_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    health_reg <= MAX_HP_V;
                    if (bus.start_level) begin
                        state_reg          <= S_DEPLOY;
                        level_complete_reg <= 1'b0;
                    end
                end

                S_DEPLOY: begin
                    position_reg  <= bus.player ? '1 : '0;
                    health_reg    <= MAX_HP_V;
                    regen_cnt_reg <= '0;
                    alive_reg     <= 1'b1;
                    state_reg     <= S_ALIVE;
                end

                S_ALIVE: begin
                    hit_reg <= dmg_any;
                    // The regen counter keeps its cadence even when damage
                    // suppresses the +1 on the wrapping tick.
                    if (REGEN_ON && bus.game_tick) begin
                        regen_cnt_reg <= regen_due ? '0 : regen_cnt_reg + RCNT_W'(1);
                    end
                    if (lethal) begin
                        health_reg         <= '0;
                        state_reg          <= S_DEAD;
                        alive_reg          <= 1'b0;
                        dead_reg           <= 1'b1;
                        level_complete_reg <= 1'b1;
                        dead_cnt_reg       <= '0;
                    end else if (dmg_any) begin
                        health_reg <= hp_after;
                    end else if (regen_due && (health_reg < MAX_HP_V)) begin
                        health_reg <= health_reg + HP_W'(1);
                    end
                end

                S_DEAD: begin
                    if (bus.game_tick) begin
                        if (dead_done) begin
                            state_reg    <= S_IDLE;
                            health_reg   <= MAX_HP_V;
                            dead_reg     <= 1'b0;
                            dead_cnt_reg <= '0;
                        end else begin
                            dead_cnt_reg <= dead_cnt_reg + DCNT_W'(1);
                        end
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                    alive_reg <= 1'b0;
                    dead_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.health         = health_reg;
    assign bus.position       = position_reg;
    assign bus.alive          = alive_reg;
    assign bus.dead           = dead_reg;
    assign bus.level_complete = level_complete_reg;
    assign bus.hit            = hit_reg;

endmodule

// File: tb/tb_tower_unit.sv
// -----------------------------------------------------------------------------
// tb_tower_unit
// Two towers share one stimulus stream: dut0 without regeneration and dut1
// with REGEN_TICKS=4. A phase-level model of each tower predicts every output
// and is compared on each falling clock edge; a directed prologue pins the
// model with hand-computed values, then a long randomized run follows.
// -----------------------------------------------------------------------------
module tb_tower_unit;
    localparam int DEAD_T = 10;
    localparam int PH_IDLE = 0, PH_DEPLOY = 1, PH_ALIVE = 2, PH_DEAD = 3;

    logic        clk;
    logic        reset;
    logic        game_tick;
    logic        start_level;
    logic        player;
    logic [1:0]  attack_en;
    logic [15:0] damage_in;

    int n_checks = 0;
    int n_fail   = 0;

    tower_unit_if #(.HP_W(8), .N_ATK(2), .DMG_W(8), .POS_W(9)) bus0 ();
    tower_unit_if #(.HP_W(8), .N_ATK(2), .DMG_W(8), .POS_W(9)) bus1 ();

    assign bus0.game_tick   = game_tick;
    assign bus0.start_level = start_level;
    assign bus0.player      = player;
    assign bus0.attack_en   = attack_en;
    assign bus0.damage_in   = damage_in;
    assign bus1.game_tick   = game_tick;
    assign bus1.start_level = start_level;
    assign bus1.player      = player;
    assign bus1.attack_en   = attack_en;
    assign bus1.damage_in   = damage_in;

    tower_unit #(.DEAD_TICKS(DEAD_T), .REGEN_TICKS(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    tower_unit #(.DEAD_TICKS(DEAD_T), .REGEN_TICKS(4)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ model
    int m_phase [2];
    int m_hp    [2];
    int m_pos   [2];
    int m_lc    [2];
    int m_hit   [2];
    int m_td    [2];   // ticks seen while dead
    int m_tr    [2];   // ticks seen since last regen boundary

    function automatic int regen_of(input int d);
        return (d == 0) ? 0 : 4;
    endfunction

    task automatic model_reset(input int d);
        m_phase[d] = PH_IDLE;
        m_hp[d]    = 255;
        m_pos[d]   = 0;
        m_lc[d]    = 0;
        m_hit[d]   = 0;
        m_td[d]    = 0;
        m_tr[d]    = 0;
    endtask

    task automatic model_step(input int d);
        int  s;
        bit  regen_now;
        s = 0;
        regen_now = 0;
        for (int i = 0; i < 2; i++)
            if (attack_en[i]) s += int'(damage_in[i*8 +: 8]);
        m_hit[d] = 0;
        case (m_phase[d])
            PH_IDLE: begin
                m_hp[d] = 255;
                if (start_level) begin
                    m_phase[d] = PH_DEPLOY;
                    m_lc[d]    = 0;
                end
            end
            PH_DEPLOY: begin
                m_pos[d]   = player ? 511 : 0;
                m_hp[d]    = 255;
                m_tr[d]    = 0;
                m_phase[d] = PH_ALIVE;
            end
            PH_ALIVE: begin
                m_hit[d] = (s != 0) ? 1 : 0;
                if (regen_of(d) > 0 && game_tick) begin
                    m_tr[d]++;
                    if (m_tr[d] == regen_of(d)) begin
                        m_tr[d]   = 0;
                        regen_now = 1;
                    end
                end
                if (s >= m_hp[d]) begin
                    m_hp[d]    = 0;
                    m_phase[d] = PH_DEAD;
                    m_lc[d]    = 1;
                    m_td[d]    = 0;
                end else if (s != 0) begin
                    m_hp[d] = m_hp[d] - s;
                end else if (regen_now && m_hp[d] < 255) begin
                    m_hp[d] = m_hp[d] + 1;
                end
            end
            default: begin
                if (game_tick) begin
                    m_td[d]++;
                    if (m_td[d] == DEAD_T) begin
                        m_phase[d] = PH_IDLE;
                        m_hp[d]    = 255;
                    end
                end
            end
        endcase
    endtask

    always @(posedge clk or posedge reset) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) model_reset(d);
            else       model_step(d);
        end
    end

    // ------------------------------------------------------------ checking
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_one(input int d, input int hp, input int pos,
                               input int al, input int de, input int lc, input int ht);
        check($sformatf("dut%0d health", d),         hp,  m_hp[d]);
        check($sformatf("dut%0d position", d),       pos, m_pos[d]);
        check($sformatf("dut%0d alive", d),          al,  (m_phase[d] == PH_ALIVE) ? 1 : 0);
        check($sformatf("dut%0d dead", d),           de,  (m_phase[d] == PH_DEAD) ? 1 : 0);
        check($sformatf("dut%0d level_complete", d), lc,  m_lc[d]);
        check($sformatf("dut%0d hit", d),            ht,  m_hit[d]);
    endtask

    always @(negedge clk) begin
        compare_one(0, int'(bus0.health), int'(bus0.position), int'(bus0.alive),
                    int'(bus0.dead), int'(bus0.level_complete), int'(bus0.hit));
        compare_one(1, int'(bus1.health), int'(bus1.position), int'(bus1.alive),
                    int'(bus1.dead), int'(bus1.level_complete), int'(bus1.hit));
    end

    // ------------------------------------------------------------ stimulus
    // Applies one cycle of inputs, waits for the edge, returns 1 time unit later.
    task automatic cyc(input bit tick, input bit start, input bit [1:0] en,
                       input int d0, input int d1);
        game_tick   = tick;
        start_level = start;
        attack_en   = en;
        damage_in   = {8'(d1), 8'(d0)};
        @(posedge clk);
        #1;
        $display("cyc t=%0t tick=%0b start=%0b en=%b dmg=%0d/%0d hp=%0d/%0d st=%0b%0b/%0b%0b",
                 $time, tick, start, en, d0, d1, bus0.health, bus1.health,
                 bus0.alive, bus0.dead, bus1.alive, bus1.dead);
    endtask

    initial begin
        reset       = 1'b1;
        game_tick   = 1'b0;
        start_level = 1'b0;
        player      = 1'b1;
        attack_en   = '0;
        damage_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset health", int'(bus0.health), 255);
        check("reset alive", int'(bus0.alive), 0);
        check("reset level_complete", int'(bus1.level_complete), 0);
        check("reset position", int'(bus1.position), 0);

        // Start, one DEPLOY cycle, then ALIVE.
        cyc(0, 1, 2'b00, 0, 0);
        check("deploy not yet alive", int'(bus0.alive), 0);
        cyc(0, 0, 2'b00, 0, 0);
        check("alive after deploy", int'(bus0.alive), 1);
        check("player position", int'(bus0.position), 9'h1FF);
        check("deploy health", int'(bus0.health), 255);
        check("deploy level_complete", int'(bus0.level_complete), 0);

        // Regen saturates at full health.
        repeat (4) cyc(1, 0, 2'b00, 0, 0);
        check("regen saturate", int'(bus1.health), 255);

        // Two channels summed; hit pulses for exactly one clk.
        cyc(0, 0, 2'b11, 10, 20);
        check("dual hit health", int'(bus0.health), 225);
        check("hit pulse", int'(bus0.hit), 1);
        cyc(0, 0, 2'b00, 0, 0);
        check("hit drop", int'(bus0.hit), 0);

        // Exact-kill: S == health.
        cyc(0, 0, 2'b01, 195, 0);
        check("health 30", int'(bus0.health), 30);
        cyc(0, 0, 2'b01, 30, 0);
        check("kill health", int'(bus0.health), 0);
        check("kill dead", int'(bus0.dead), 1);
        check("kill level_complete", int'(bus0.level_complete), 1);

        // Death hold: 9 ticks stay dead (attacks and start ignored), 10th leaves.
        repeat (9) cyc(1, 1, 2'b11, 50, 50);
        check("dead after 9 ticks", int'(bus0.dead), 1);
        cyc(1, 0, 2'b00, 0, 0);
        check("idle dead", int'(bus0.dead), 0);
        check("idle health", int'(bus0.health), 255);
        check("idle level_complete held", int'(bus0.level_complete), 1);
        cyc(0, 1, 2'b00, 0, 0);
        check("start clears level_complete", int'(bus0.level_complete), 0);
        cyc(0, 0, 2'b00, 0, 0);

        // Overkill with both channels must not wrap.
        cyc(0, 0, 2'b01, 205, 0);
        check("health 50", int'(bus1.health), 50);
        cyc(0, 0, 2'b11, 200, 200);
        check("overkill health", int'(bus1.health), 0);
        check("overkill dead", int'(bus1.dead), 1);
        repeat (DEAD_T) cyc(1, 0, 2'b00, 0, 0);
        cyc(0, 1, 2'b00, 0, 0);
        cyc(0, 0, 2'b00, 0, 0);

        // Regeneration on dut1 only.
        cyc(0, 0, 2'b01, 155, 0);
        repeat (4) cyc(1, 0, 2'b00, 0, 0);
        check("regen +1", int'(bus1.health), 101);
        check("no regen", int'(bus0.health), 100);
        repeat (3) cyc(1, 0, 2'b00, 0, 0);
        cyc(1, 0, 2'b01, 5, 0);
        check("damage beats regen", int'(bus1.health), 96);
        check("damage no regen", int'(bus0.health), 95);

        // start_level while ALIVE has no effect.
        cyc(0, 1, 2'b00, 0, 0);
        check("start ignored in alive", int'(bus1.alive), 1);
        cyc(0, 0, 2'b01, 54, 0);
        check("health 42", int'(bus1.health), 42);

        // Asynchronous reset takes effect without a clock edge.
        reset = 1'b1;
        #1;
        check("async reset health", int'(bus1.health), 255);
        check("async reset alive", int'(bus1.alive), 0);
        check("async reset dead", int'(bus1.dead), 0);
        check("async reset level_complete", int'(bus1.level_complete), 0);
        check("async reset hit", int'(bus1.hit), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Randomized run.
        for (int n = 0; n < 4000; n++) begin
            int d0, d1;
            player = 1'($urandom_range(0, 1));
            reset  = ($urandom_range(0, 499) == 0);
            d0 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 11);
            d1 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 11);
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                2'($urandom_range(0, 3)), d0, d1);
        end
        reset = 1'b0;
        cyc(0, 0, 2'b00, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tower_unit.md
Name: tower_unit

Overview:
- Parametrised successor of the per-side tower block. Holds one tower's hit points, deploy position and life state for a level.
- Accepts N_ATK independent damage channels per cycle, with optional passive regeneration and a death-hold window timed in game ticks.
- Instantiated once per side (player/enemy) under the level controller. Runs on the system clock, with gameplay timing taken from a game_tick enable.

Parameters:
- HP_W, 8, width of health.
- MAX_HP, 255, health loaded at level start; must fit in HP_W bits.
- N_ATK, 2, number of damage input channels.
- DMG_W, 8, width of each damage value.
- POS_W, 9, width of position.
- DEAD_TICKS, 10, game ticks spent in DEAD before returning to IDLE.
- REGEN_TICKS, 0, game ticks per +1 health regeneration; 0 disables regen.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- game_tick  in  1  one-clk-wide gameplay tick enable.
- start_level  in  1  level start request; sampled in IDLE only.
- player  in  1  1 = player tower (right side), 0 = enemy tower (left side).
- attack_en  in  N_ATK  per-channel attack valid.
- damage_in  in  N_ATK*DMG_W  packed damage; channel i is bits [i*DMG_W +: DMG_W].
- health  out  HP_W  current hit points.
- position  out  POS_W  deploy x-position.
- alive  out  1  high in ALIVE.
- dead  out  1  high in DEAD.
- level_complete  out  1  set on entry to DEAD; held until the next start_level is accepted.
- hit  out  1  one-clk pulse when nonzero damage is applied.

Behaviour:
- Reset values (asynchronous): state=IDLE, health=MAX_HP, position=0, alive=0, dead=0, level_complete=0, hit=0, tick and regen counters=0.
- IDLE state:
  - health held at MAX_HP.
  - When start_level=1: go to DEPLOY, clear level_complete.
- DEPLOY state (1 clk):
  - position loaded with all-ones if player=1, otherwise 0.
  - health reloaded to MAX_HP.
  - Unconditional transition to ALIVE.
- ALIVE state, damage:
  - Damage sum S = sum over i of (attack_en[i] ? damage_in[i] : 0), computed at width DMG_W+clog2(N_ATK)+1 with no overflow.
  - If S >= health: health<=0 and go to DEAD in the same clk.
  - Else: health <= health - S.
  - hit=1 the clk after the update when S != 0.
  - Damage is applied every clk regardless of game_tick.
- ALIVE state, regen (REGEN_TICKS>0 only):
  - regen counter increments on game_tick.
  - When it reaches REGEN_TICKS-1 on a tick: counter clears and health += 1, saturating at MAX_HP.
  - If S != 0 in that same clk, damage wins: regen is skipped for that clk but the counter still clears.
- DEAD state:
  - Entered with health=0, dead=1, level_complete=1, tick counter=0.
  - Counter increments on game_tick.
  - When the counter reaches DEAD_TICKS-1 on a tick: go to IDLE, health reloads to MAX_HP, dead=0.
  - level_complete stays 1 in IDLE until start_level is accepted.
  - attack_en is ignored in DEAD.
- start_level is ignored outside IDLE.
- Asynchronous reset mid-level returns to reset values immediately.
- Unreachable state encodings recover to IDLE on the next clk.
- All outputs are registered.

Test Plan:
- Reset, then start_level=1 with player=1 -> DEPLOY for 1 clk, then ALIVE; position=9'h1FF, health=255, level_complete=0.
- ALIVE with health=255; ch0=10 and ch1=20 both enabled for 1 clk -> health=225 next clk, hit pulses once for 1 clk.
- health=30; ch0=30 enabled -> health=0, dead=1, level_complete=1; with both channels 200+200 from health=50 -> health=0, no wrap to a large value.
- In DEAD with DEAD_TICKS=10: issue 9 game_ticks -> still DEAD; 10th tick -> IDLE, health=255, dead=0, level_complete still 1; next start_level clears it.
- REGEN_TICKS=4, health=100: 4 ticks with no damage -> health=101. At health=255, 4 ticks -> stays 255. Tick coinciding with 5 damage -> health=96.
- Assert reset while in ALIVE with health=42 -> same cycle: health=255, state IDLE, all flags 0; start_level during ALIVE -> no effect.
